// File: rtl/cond_pkg.sv
// Shared condition-code constants, NZCV bit positions and writeback FSM encoding.
package cond_pkg;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_VS = 4'b0110;
  localparam logic [3:0] CC_VC = 4'b0111;
  localparam logic [3:0] CC_HI = 4'b1000;
  localparam logic [3:0] CC_LS = 4'b1001;
  localparam logic [3:0] CC_GE = 4'b1010;
  localparam logic [3:0] CC_LT = 4'b1011;
  localparam logic [3:0] CC_GT = 4'b1100;
  localparam logic [3:0] CC_LE = 4'b1101;
  localparam logic [3:0] CC_AL = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_HI_WR = 1'b1
  } wb_state_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation of Cond against an NZCV value.
// Latency 0; no flow control. Shared with the branch unit.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      CC_EQ:   CondEx = z;
      CC_NE:   CondEx = ~z;
      CC_CS:   CondEx = c;
      CC_CC:   CondEx = ~c;
      CC_MI:   CondEx = n;
      CC_PL:   CondEx = ~n;
      CC_VS:   CondEx = v;
      CC_VC:   CondEx = ~v;
      CC_HI:   CondEx = c & ~z;
      CC_LS:   CondEx = ~c | z;
      CC_GE:   CondEx = (n == v);
      CC_LT:   CondEx = (n != v);
      CC_GT:   CondEx = ~z & (n == v);
      CC_LE:   CondEx = z | (n != v);
      CC_AL:   CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_writeback.sv
// Conditional writeback: holds NZCV, gates reg/mem/PC writes, splits long multiplies into two writes.
// Latency 1 cycle (high word of a long multiply lands 1 cycle later); Stall holds upstream for that cycle.
// Optional SQUASH_COUNT_EN adds a saturating count of accepted-but-squashed instructions.
module cond_writeback
  import cond_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RA_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Valid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             PCS,
  input  logic             Long,
  input  logic [WIDTH-1:0] Result,
  input  logic [WIDTH-1:0] ResultExtra,
  input  logic [RA_W-1:0]  RdLo,
  input  logic [RA_W-1:0]  RdHi,
  output logic             RegWrite,
  output logic [RA_W-1:0]  WA3,
  output logic [WIDTH-1:0] WD3,
  output logic             MemWrite,
  output logic             PCSrc,
  output logic             Stall,
  output logic [3:0]       Flags
`ifdef SQUASH_COUNT_EN
  ,
  output logic [15:0]      SquashCount
`endif
);

  wb_state_t        state;
  logic [RA_W-1:0]  hi_wa;
  logic [WIDTH-1:0] hi_wd;
  logic             cond_ex;
  logic             accept;
  logic             exec;

  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (cond_ex)
  );

  assign accept = Valid & (state == ST_IDLE);
  assign exec   = accept & cond_ex;
  assign Stall  = (state == ST_HI_WR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      RegWrite <= 1'b0;
      WA3      <= '0;
      WD3      <= '0;
      MemWrite <= 1'b0;
      PCSrc    <= 1'b0;
      Flags    <= '0;
      hi_wa    <= '0;
      hi_wd    <= '0;
    end else begin
      RegWrite <= 1'b0;
      MemWrite <= 1'b0;
      PCSrc    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (exec) begin
            if (FlagW[1]) begin
              Flags[FLAG_N] <= ALUFlags[FLAG_N];
              Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagW[0]) begin
              Flags[FLAG_C] <= ALUFlags[FLAG_C];
              Flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
            if (!Long) begin
              RegWrite <= RegW;
              WA3      <= RdLo;
              WD3      <= Result;
              MemWrite <= MemW;
              PCSrc    <= PCS;
            end else if (RegW) begin
              // Low word now; high word is parked for the stall cycle so it lands last.
              RegWrite <= 1'b1;
              WA3      <= RdLo;
              WD3      <= Result;
              hi_wa    <= RdHi;
              hi_wd    <= ResultExtra;
              state    <= ST_HI_WR;
            end
          end
        end
        ST_HI_WR: begin
          RegWrite <= 1'b1;
          WA3      <= hi_wa;
          WD3      <= hi_wd;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SQUASH_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      SquashCount <= '0;
    end else if (accept && !cond_ex && (SquashCount != 16'hFFFF)) begin
      SquashCount <= SquashCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cond_writeback.sv
// Directed bench for cond_writeback: stimulus pushes per-cycle expectations, a monitor pops and checks them.
`timescale 1ns/1ps
module tb_cond_writeback;
  import cond_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Valid;
  logic [3:0]  Cond;
  logic [3:0]  ALUFlags;
  logic [1:0]  FlagW;
  logic        RegW, MemW, PCS, Long;
  logic [31:0] Result, ResultExtra;
  logic [3:0]  RdLo, RdHi;
  logic        RegWrite, MemWrite, PCSrc, Stall;
  logic [3:0]  WA3;
  logic [31:0] WD3;
  logic [3:0]  Flags;
`ifdef SQUASH_COUNT_EN
  logic [15:0] SquashCount;
`endif

  always #5 clk = ~clk;

  cond_writeback #(.WIDTH(32), .RA_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .Valid       (Valid),
    .Cond        (Cond),
    .ALUFlags    (ALUFlags),
    .FlagW       (FlagW),
    .RegW        (RegW),
    .MemW        (MemW),
    .PCS         (PCS),
    .Long        (Long),
    .Result      (Result),
    .ResultExtra (ResultExtra),
    .RdLo        (RdLo),
    .RdHi        (RdHi),
    .RegWrite    (RegWrite),
    .WA3         (WA3),
    .WD3         (WD3),
    .MemWrite    (MemWrite),
    .PCSrc       (PCSrc),
    .Stall       (Stall),
    .Flags       (Flags)
`ifdef SQUASH_COUNT_EN
    ,
    .SquashCount (SquashCount)
`endif
  );

  typedef struct {
    logic        rst, vld;
    logic [3:0]  cond, aluf;
    logic [1:0]  fw;
    logic        rw, mw, pcs, lng;
    logic [3:0]  rlo, rhi;
    logic [31:0] res, rex;
  } instr_t;

  typedef struct {
    logic        rw, mw, pcs, stall;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  flags;
    logic [15:0] sq;
  } exp_t;

  exp_t        expq[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [15:0] exp_sq = '0;

  function automatic instr_t mk(input logic [3:0] cond, input logic [1:0] fw, input logic [3:0] aluf,
                                input logic rw, input logic mw, input logic pcs, input logic lng,
                                input logic [3:0] rlo, input logic [3:0] rhi,
                                input logic [31:0] res, input logic [31:0] rex);
    instr_t i;
    i.rst = 1'b0; i.vld = 1'b1; i.cond = cond; i.fw = fw; i.aluf = aluf;
    i.rw = rw; i.mw = mw; i.pcs = pcs; i.lng = lng;
    i.rlo = rlo; i.rhi = rhi; i.res = res; i.rex = rex;
    return i;
  endfunction

  function automatic instr_t nop(input logic rst);
    instr_t i;
    i = mk(CC_AL, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
    i.vld = 1'b0;
    i.rst = rst;
    return i;
  endfunction

  // Independent statement of the ARM condition table, used for the full sweep.
  function automatic logic cc_model(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input instr_t i, input logic rw, input logic mw, input logic pcs, input logic stall,
                      input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] flags, input logic squash);
    exp_t e;
    @(negedge clk);
    reset = i.rst; Valid = i.vld; Cond = i.cond; ALUFlags = i.aluf; FlagW = i.fw;
    RegW = i.rw; MemW = i.mw; PCS = i.pcs; Long = i.lng;
    RdLo = i.rlo; RdHi = i.rhi; Result = i.res; ResultExtra = i.rex;
    if (i.rst) exp_sq = '0;
    else if (squash && exp_sq != 16'hFFFF) exp_sq = exp_sq + 16'd1;
    e.rw = rw; e.mw = mw; e.pcs = pcs; e.stall = stall;
    e.wa = wa; e.wd = wd; e.flags = flags; e.sq = exp_sq;
    expq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, want);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (expq.size() > 0) begin
        exp_t e;
        e = expq.pop_front();
        chk("RegWrite", {31'd0, RegWrite}, {31'd0, e.rw});
        chk("MemWrite", {31'd0, MemWrite}, {31'd0, e.mw});
        chk("PCSrc",    {31'd0, PCSrc},    {31'd0, e.pcs});
        chk("Stall",    {31'd0, Stall},    {31'd0, e.stall});
        chk("WA3",      {28'd0, WA3},      {28'd0, e.wa});
        chk("WD3",      WD3,               e.wd);
        chk("Flags",    {28'd0, Flags},    {28'd0, e.flags});
`ifdef SQUASH_COUNT_EN
        chk("SquashCount", {16'd0, SquashCount}, {16'd0, e.sq});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic pass;
    reset = 1'b1; Valid = 1'b0; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
    RegW = 1'b0; MemW = 1'b0; PCS = 1'b0; Long = 1'b0;
    RdLo = 4'h0; RdHi = 4'h0; Result = 32'h0; ResultExtra = 32'h0;

    // Reset state
    step(nop(1'b1), 0, 0, 0, 0, 4'h0, 32'h0, 4'h0, 0);
    step(nop(1'b1), 0, 0, 0, 0, 4'h0, 32'h0, 4'h0, 0);
    // ADD setting Z, then BEQ taken, BNE squashed
    step(mk(CC_AL, 2'b11, 4'b0100, 1, 0, 0, 0, 4'd1, 4'd0, 32'd7, 32'd0),   1, 0, 0, 0, 4'd1, 32'd7,     4'b0100, 0);
    step(mk(CC_EQ, 2'b00, 4'b0000, 0, 0, 1, 0, 4'd0, 4'd0, 32'h100, 32'd0), 0, 0, 1, 0, 4'd0, 32'h100,   4'b0100, 0);
    step(mk(CC_NE, 2'b00, 4'b0000, 0, 0, 1, 0, 4'd0, 4'd0, 32'h200, 32'd0), 0, 0, 0, 0, 4'd0, 32'h100,   4'b0100, 1);
    // Clear flags, MOVEQ squashed, STR passes MemWrite
    step(mk(CC_AL, 2'b11, 4'b0000, 0, 0, 0, 0, 4'd0, 4'd0, 32'h0, 32'd0),   0, 0, 0, 0, 4'd0, 32'h0,     4'b0000, 0);
    step(mk(CC_EQ, 2'b00, 4'b0000, 1, 0, 0, 0, 4'd3, 4'd0, 32'h5, 32'd0),   0, 0, 0, 0, 4'd0, 32'h0,     4'b0000, 1);
    step(mk(CC_AL, 2'b00, 4'b0000, 0, 1, 0, 0, 4'd6, 4'd0, 32'h40, 32'd0),  0, 1, 0, 0, 4'd6, 32'h40,    4'b0000, 0);
    // Squashed instruction must not touch flags
    step(mk(CC_EQ, 2'b11, 4'b1111, 1, 1, 1, 0, 4'd9, 4'd0, 32'h99, 32'd0),  0, 0, 0, 0, 4'd6, 32'h40,    4'b0000, 1);
    // UMULL; the instruction presented during the stall is ignored
    step(mk(CC_AL, 2'b00, 4'b0000, 1, 0, 0, 1, 4'd2, 4'd4, 32'hDEADBEEF, 32'h1), 1, 0, 0, 1, 4'd2, 32'hDEADBEEF, 4'b0000, 0);
    step(mk(CC_AL, 2'b11, 4'b1111, 1, 1, 1, 0, 4'd9, 4'd0, 32'h99, 32'd0),  1, 0, 0, 0, 4'd4, 32'h1,     4'b0000, 0);
    step(nop(1'b0),                                                          0, 0, 0, 0, 4'd4, 32'h1,     4'b0000, 0);
    // SMULL with RdLo==RdHi: high word written last
    step(mk(CC_AL, 2'b10, 4'b1000, 1, 0, 0, 1, 4'd5, 4'd5, 32'hAAAA, 32'hBBBB), 1, 0, 0, 1, 4'd5, 32'hAAAA, 4'b1000, 0);
    step(nop(1'b0),                                                          1, 0, 0, 0, 4'd5, 32'hBBBB,  4'b1000, 0);
    step(nop(1'b0),                                                          0, 0, 0, 0, 4'd5, 32'hBBBB,  4'b1000, 0);
    // Long without RegW: no write, no stall, next instruction accepted at once
    step(mk(CC_AL, 2'b00, 4'b0000, 0, 0, 0, 1, 4'd7, 4'd8, 32'h77, 32'h88), 0, 0, 0, 0, 4'd5, 32'hBBBB,  4'b1000, 0);
    step(mk(CC_AL, 2'b00, 4'b0000, 1, 0, 0, 0, 4'd1, 4'd0, 32'h3, 32'd0),   1, 0, 0, 0, 4'd1, 32'h3,     4'b1000, 0);
    // Reset during HI_WR drops the high word
    step(mk(CC_AL, 2'b11, 4'b0110, 1, 0, 0, 1, 4'd2, 4'd4, 32'h11, 32'h22), 1, 0, 0, 1, 4'd2, 32'h11,    4'b0110, 0);
    step(nop(1'b1),                                                          0, 0, 0, 0, 4'd0, 32'h0,     4'b0000, 0);
    step(nop(1'b0),                                                          0, 0, 0, 0, 4'd0, 32'h0,     4'b0000, 0);
    step(mk(CC_AL, 2'b00, 4'b0000, 1, 0, 0, 0, 4'd3, 4'd0, 32'h5, 32'd0),   1, 0, 0, 0, 4'd3, 32'h5,     4'b0000, 0);

    // Every condition code against every NZCV value, seen through PCSrc
    for (int f = 0; f < 16; f++) begin
      for (int cc = 0; cc < 16; cc++) begin
        step(mk(CC_AL, 2'b11, 4'(f), 0, 0, 0, 0, 4'd0, 4'd0, 32'h0, 32'd0),   0, 0, 0, 0, 4'd0, 32'h0, 4'(f), 0);
        pass = cc_model(4'(cc), 4'(f));
        step(mk(4'(cc), 2'b00, 4'h0, 0, 0, 1, 0, 4'd0, 4'd0, 32'h0, 32'd0), 0, 0, pass, 0, 4'd0, 32'h0, 4'(f), !pass);
      end
    end
    step(nop(1'b0), 0, 0, 0, 0, 4'd0, 32'h0, 4'hF, 0);

    @(posedge clk);
    #3;
    chk("scoreboard_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cond_writeback.md
Name: cond_writeback

Overview:
- Stage directly downstream of the ALU. Consumes ALUFlags, Result and ResultExtra.
- Holds the architectural NZCV register and evaluates the ARM condition field against it.
- Gates register, memory and PC writes for the instruction.
- Sequences a 64-bit long-multiply result (SMULL/UMULL) into two single-port register-file writes, stalling upstream for one cycle.

Parameters:
- WIDTH, 32, datapath width of Result/ResultExtra/WD3.
- RA_W, 4, register-address width (R0..R15).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- Valid  in  1  instruction present from ALU stage.
- Cond  in  4  ARM condition field.
- ALUFlags  in  4  {N,Z,C,V} from ALU for this instruction.
- FlagW  in  2  bit1: update N,Z; bit0: update C,V.
- RegW  in  1  instruction writes register(s).
- MemW  in  1  instruction writes memory.
- PCS  in  1  instruction writes PC.
- Long  in  1  64-bit result (SMULL/UMULL); Result to RdLo, ResultExtra to RdHi.
- Result  in  WIDTH  low/only result word.
- ResultExtra  in  WIDTH  high result word.
- RdLo  in  RA_W  destination for Result.
- RdHi  in  RA_W  destination for ResultExtra (Long only).
- RegWrite  out  1  register-file write enable (registered).
- WA3  out  RA_W  write address (registered).
- WD3  out  WIDTH  write data (registered).
- MemWrite  out  1  registered.
- PCSrc  out  1  registered.
- Stall  out  1  upstream must hold and re-present its instruction.
- Flags  out  4  current NZCV register.

Behaviour:
- Reset: RegWrite, WA3, WD3, MemWrite, PCSrc, Stall, Flags all 0; FSM to IDLE; any latched high word is discarded.
- CondEx (combinational) uses the current Flags register:
  - EQ 0000 Z; NE 0001 ~Z; CS 0010 C; CC 0011 ~C; MI 0100 N; PL 0101 ~N; VS 0110 V; VC 0111 ~V.
  - HI 1000 C&~Z; LS 1001 ~C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 ~Z&(N==V); LE 1101 Z|(N!=V).
  - AL 1110 1; 1111 0.
- Accept = Valid & (state==IDLE). Exec = Accept & CondEx.
- Flags update on Exec only; visible to the very next accepted instruction:
  - FlagW[1] loads N,Z from ALUFlags[3:2].
  - FlagW[0] loads C,V from ALUFlags[1:0].
- FSM states IDLE and HI_WR:
  - IDLE, Exec & ~Long: next cycle RegWrite=RegW, WA3=RdLo, WD3=Result, MemWrite=MemW, PCSrc=PCS. Stay IDLE. Latency 1.
  - IDLE, Exec & Long & RegW: next cycle RegWrite=1, WA3=RdLo, WD3=Result, MemWrite=0, PCSrc=0. Latch RdHi and ResultExtra. Go to HI_WR.
  - HI_WR: Stall=1 (Moore, decoded from state); inputs ignored. Next cycle RegWrite=1, WA3=latched RdHi, WD3=latched ResultExtra. Return to IDLE.
  - Long & ~RegW: treated as no-write; remains IDLE.
- Not Exec (squashed, or Valid=0): next cycle RegWrite/MemWrite/PCSrc=0. WA3/WD3 hold their previous values.
- RdLo==RdHi on Long: both writes issued in order; the high word is last, so it wins.
- Reset asserted in HI_WR: high write dropped; IDLE next cycle.
- Stall is never asserted in IDLE. The maximum stall is one cycle per Long instruction.

Optional Feature:
- Macro SQUASH_COUNT_EN.
- Defined: adds output SquashCount (16 bits). It increments on each Accept with CondEx=0, saturates at 16'hFFFF, and is cleared by reset.
- Undefined: no port and no counter logic. Functional behaviour is otherwise identical.

Decomposition:
- Shared package cond_pkg:
  - 4-bit condition-code constants (EQ..AL, NV).
  - Flag bit indices N=3, Z=2, C=1, V=0.
  - FSM state encoding IDLE/HI_WR.
- One sub-module cond_check: purely combinational (Cond, Flags) -> CondEx. It is reused by the branch unit.

Test Plan:
- ADD with FlagW=11 and ALUFlags=0100 -> Flags=0100 next cycle. A following BEQ (Cond=0000, PCS=1) -> PCSrc=1. BNE -> PCSrc=0.
- Flags=0000, MOVEQ RegW=1, RdLo=3, Result=32'h5 -> RegWrite=0 next cycle; with SQUASH_COUNT_EN, SquashCount=1.
- UMULL AL, Long=1, RdLo=2, RdHi=4, Result=32'hDEADBEEF, ResultExtra=32'h1 -> cycle+1: WA3=2, WD3=DEADBEEF, Stall=1; cycle+2: WA3=4, WD3=1, Stall=0. The instruction presented during the stall cycle is ignored.
- SMULL with RdLo=RdHi=5 -> two writes to R5, last WD3=ResultExtra.
- reset=1 during HI_WR -> RegWrite=0, Stall=0, Flags=0 next cycle; no high-word write.
- GE/LT/GT/LE sweep over all 16 Flags values -> CondEx matches the table.
